inst_loader: RTL and testbench

- Write-side master for the instruction buffer.
- Accepts a byte stream over a valid/ready handshake and assembles 4 bytes into one instruction word.
- Drives the buffer's write port (write_en, buffer_write_data, buffer_write_addr) sequentially from address 0.
- Stops on a halt instruction (top two bits 2'b11) or when the buffer is full; sits between the host download path and the buffer.

---
 rtl/inst_loader_if.sv | 23 ++
 rtl/inst_loader.sv | 156 +++++++++++++++
 tb/tb_inst_loader.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_loader_if.sv
// Byte-stream input and instruction-buffer write port of the instruction loader.
// master: the loader side; slave: the host stream source / buffer side.
interface inst_loader_if #(
  parameter int INST_WIDTH = 25,
  parameter int INST_COUNT = 64
);
  logic                          in_valid;
  logic [7:0]                    in_data;
  logic                          in_ready;
  logic                          write_en;
  logic [INST_WIDTH-1:0]         buffer_write_data;
  logic [$clog2(INST_COUNT)-1:0] buffer_write_addr;

  modport master (
    input  in_valid, in_data,
    output in_ready, write_en, buffer_write_data, buffer_write_addr
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, write_en, buffer_write_data, buffer_write_addr
  );
endinterface

// File: rtl/inst_loader.sv
// Instruction-buffer loader: packs 4 stream bytes (little-endian) per instruction and writes
// them from address 0 until a halt word or a full buffer. INST_LOADER_CHECKSUM_EN adds a trailing XOR byte check.
module inst_loader #(
  parameter int INST_WIDTH = 25,
  parameter int INST_COUNT = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  inst_loader_if.master                 bus,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow,
  output logic                          checksum_err,
  output logic [$clog2(INST_COUNT):0]   inst_count
);
  localparam int            AW        = $clog2(INST_COUNT);
  localparam logic [AW-1:0] LAST_ADDR = AW'(INST_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
`ifdef INST_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE
  } state_t;

  // Where a load goes after its terminating write.
`ifdef INST_LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CHECK;
`else
  localparam state_t S_END = S_DONE;
`endif

  state_t                state_q, state_d;
  logic [1:0]            byte_cnt;
  logic [INST_WIDTH-1:0] word_q;
  logic [AW-1:0]         addr_q;
  logic                  in_ready_c;
  logic                  write_c;
  logic                  accept;
  logic                  load_start;
  logic                  is_halt;
  logic                  at_last;

  assign is_halt = (word_q[INST_WIDTH-1 -: 2] == 2'b11);
  assign at_last = (addr_q == LAST_ADDR);

  assign bus.in_ready          = in_ready_c;
  assign bus.write_en          = write_c;
  assign bus.buffer_write_data = word_q;
  assign bus.buffer_write_addr = addr_q;

`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0] xor_q;
  logic       chk_accept;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    write_c    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    load_start = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
    chk_accept = 1'b0;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (start) begin
          load_start = 1'b1;
          state_d    = S_COLLECT;
        end
      end
      S_COLLECT: begin
        in_ready_c = 1'b1;
        busy       = 1'b1;
        accept     = bus.in_valid;
        if (bus.in_valid && byte_cnt == 2'd3) state_d = S_WRITE;
      end
      S_WRITE: begin
        busy    = 1'b1;
        write_c = 1'b1;
        state_d = (is_halt || at_last) ? S_END : S_COLLECT;
      end
`ifdef INST_LOADER_CHECKSUM_EN
      S_CHECK: begin
        in_ready_c = 1'b1;
        busy       = 1'b1;
        chk_accept = bus.in_valid;
        if (bus.in_valid) state_d = S_DONE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt   <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      inst_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (load_start) begin
        byte_cnt   <= '0;
        addr_q     <= '0;
        inst_count <= '0;
        overflow   <= 1'b0;
      end
      // Byte k lands in bits [8k+7:8k]; bits past INST_WIDTH are simply not stored.
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        for (int i = 0; i < INST_WIDTH; i++)
          if (byte_cnt == 2'(i / 8)) word_q[i] <= bus.in_data[i % 8];
      end
      if (write_c) begin
        inst_count <= inst_count + (AW + 1)'(1);
        if (!is_halt) begin
          if (at_last) overflow <= 1'b1;
          else         addr_q   <= addr_q + AW'(1);
        end
      end
    end
  end

`ifdef INST_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xor_q        <= '0;
      checksum_err <= 1'b0;
    end else begin
      if (load_start) begin
        xor_q        <= '0;
        checksum_err <= 1'b0;
      end
      if (accept)     xor_q        <= xor_q ^ bus.in_data;
      if (chk_accept) checksum_err <= (bus.in_data != xor_q);
    end
  end
`else
  assign checksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_loader.sv
// Randomized bench for inst_loader: word lists are scored against a list-walking reference
// (halt / full-buffer termination, XOR of consumed bytes) plus directed reset/start cases.
module tb_inst_loader;
  localparam int W  = 25;
  localparam int N  = 8;
  localparam int AW = $clog2(N);
`ifdef INST_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, overflow, checksum_err;
  logic [AW:0]   inst_count;

  inst_loader_if #(.INST_WIDTH(W), .INST_COUNT(N)) bus ();

  inst_loader #(.INST_WIDTH(W), .INST_COUNT(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .checksum_err (checksum_err),
    .inst_count   (inst_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0]   wq[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [W-1:0]  wr_data_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Buffer-side monitor: log every write, and the stream must be stalled while writing.
  always @(negedge clk) begin
    if (bus.write_en === 1'b1) begin
      wr_addr_q.push_back(bus.buffer_write_addr);
      wr_data_q.push_back(bus.buffer_write_data);
      check("in_ready_during_write", bus.in_ready, 0);
    end
  end

  function automatic bit halt_of(input logic [31:0] w);
    return w[W-1 -: 2] == 2'b11;
  endfunction

  function automatic logic [31:0] rand_word(input bit halt);
    logic [31:0] w;
    w = $urandom;
    if (halt)               w[W-1 -: 2] = 2'b11;
    else if (halt_of(w))    w[W-2]      = 1'b0;
    return w;
  endfunction

  task automatic build(input int len, input bit end_halt);
    wq.delete();
    for (int i = 0; i < len; i++) wq.push_back(rand_word(end_halt && i == len - 1));
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int n;
    int gap;
    gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    bus.in_valid = 1'b0;
    repeat (gap) begin
      bus.in_data = 8'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("byte_accept_timeout", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input int maxgap, input bit bad_ck, input bit glitch, input bit skip_start);
    int          exp_n;
    bit          exp_ovf;
    logic [7:0]  ck;
    int          n;
    exp_n   = 0;
    exp_ovf = 1'b0;
    ck      = 8'h00;
    foreach (wq[i]) begin
      exp_n++;
      ck = ck ^ wq[i][7:0] ^ wq[i][15:8] ^ wq[i][23:16] ^ wq[i][31:24];
      if (halt_of(wq[i])) break;
      if (exp_n == N) begin
        exp_ovf = 1'b1;
        break;
      end
    end
    wr_addr_q.delete();
    wr_data_q.delete();
    if (!skip_start) pulse_start();
    for (int i = 0; i < exp_n; i++) begin
      if (glitch && i == 1) pulse_start();
      for (int k = 0; k < 4; k++) send_byte(wq[i][8*k +: 8], maxgap);
    end
    if (CK_EN) send_byte(bad_ck ? ~ck : ck, maxgap);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("done", done, 1);
    check("busy_at_done", busy, 0);
    check("in_ready_at_done", bus.in_ready, 0);
    check("overflow", overflow, exp_ovf);
    check("inst_count", inst_count, exp_n);
    check("checksum_err", checksum_err, CK_EN && bad_ck);
    check("write_count", wr_addr_q.size(), exp_n);
    for (int i = 0; i < exp_n && i < wr_addr_q.size(); i++) begin
      check($sformatf("write_addr[%0d]", i), wr_addr_q[i], i);
      check($sformatf("write_data[%0d]", i), wr_data_q[i], wq[i][W-1:0]);
    end
  endtask

  initial begin
    int len;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_write_en", bus.write_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_checksum_err", checksum_err, 0);
    check("rst_addr", bus.buffer_write_addr, 0);
    check("rst_data", bus.buffer_write_data, 0);
    check("rst_inst_count", inst_count, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_in_ready", bus.in_ready, 0);
    check("idle_done", done, 0);

    // Two-word load ending on a halt word (top two of 25 bits set)
    wq = '{32'h0000_0001, 32'h0180_0002};
    run_load(0, 1'b0, 1'b0, 1'b0);
    // Same stream with idle gaps between bytes; also a bad trailing checksum
    run_load(3, 1'b1, 1'b0, 1'b0);

    // Full buffer with no halt
    build(N + 2, 1'b0);
    run_load(1, 1'b0, 1'b0, 1'b0);

    // start in DONE restarts at address 0 and clears status
    pulse_start();
    check("restart_done", done, 0);
    check("restart_busy", busy, 1);
    check("restart_addr", bus.buffer_write_addr, 0);
    check("restart_inst_count", inst_count, 0);
    check("restart_overflow", overflow, 0);
    build(3, 1'b1);
    run_load(2, 1'b0, 1'b0, 1'b1);

    // Halt landing in the last slot: full, but not an overflow
    build(N, 1'b1);
    run_load(0, 1'b0, 1'b0, 1'b0);

    // start pulses while busy are ignored
    build(5, 1'b1);
    run_load(2, 1'b0, 1'b1, 1'b0);

    // Reset two bytes into the second word
    build(4, 1'b1);
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start();
    for (int k = 0; k < 4; k++) send_byte(wq[0][8*k +: 8], 1);
    for (int k = 0; k < 2; k++) send_byte(wq[1][8*k +: 8], 1);
    #2 reset = 1'b1;
    #1;
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_write_en", bus.write_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_inst_count", inst_count, 0);
    check("midrst_writes", wr_addr_q.size(), 1);
    if (wr_addr_q.size() > 0) begin
      check("midrst_addr0", wr_addr_q[0], 0);
      check("midrst_data0", wr_data_q[0], wq[0][W-1:0]);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("postrst_no_writes", wr_addr_q.size(), 1);
    check("postrst_done", done, 0);
    run_load(1, 1'b0, 1'b0, 1'b0);

    // Random loads: random length, halt or overflow termination, random gaps
    for (int t = 0; t < 6; t++) begin
      len = $urandom_range(N + 1, 1);
      build(len, len <= N);
      run_load(int'($urandom_range(3, 0)), 1'($urandom), 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
